// File: rtl/dmem_ctrl.sv
// Data-memory controller: byte/half/word loads and stores to a single-port word RAM.
// Sub-word stores use a read-modify-write so that the neighbouring bytes are preserved.
module dmem_ctrl #(
  parameter int ADDR_W = 12
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              req_i,
  input  logic              wr_i,
  input  logic [1:0]        size_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic              ready_o,
  output logic              rvalid_o,
  output logic [31:0]       rdata_o,
  output logic              err_o
);

  localparam int IDX_W = ADDR_W - 2;
  localparam int DEPTH = 1 << IDX_W;

  typedef enum logic [1:0] {IDLE, RMW, RESP} state_e;

  state_e state_d, state_q;

  logic [31:0]      mem [0:DEPTH-1];
  logic [31:0]      holdWord_q;
  logic             wr_q;
  logic [1:0]       size_q;
  logic [1:0]       off_q;
  logic [IDX_W-1:0] idx_q;
  logic [15:0]      wdata_q;
  logic             err_q;

  logic             accept;
  logic             misaligned;
  logic             memWe;
  logic             memRe;
  logic [IDX_W-1:0] memIdx;
  logic [31:0]      memWdata;
  logic [31:0]      mergedWord;
  logic [31:0]      loadWord;

  assign accept = req_i && (state_q == IDLE);

  always_comb begin
    misaligned = 1'b0;
    case (size_i)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = addr_i[0];
      2'b10:   misaligned = |addr_i[1:0];
      default: misaligned = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (!misaligned && wr_i && size_i != 2'b10) state_d = RMW;
          else                                         state_d = RESP;
        end
      end
      RMW:     state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready_o  = (state_q == IDLE);
    rvalid_o = (state_q == RESP);
    err_o    = (state_q == RESP) && err_q;
    rdata_o  = 32'h0;
    if (state_q == RESP && !wr_q && !err_q) rdata_o = loadWord;
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      wr_q    <= 1'b0;
      size_q  <= 2'b00;
      off_q   <= 2'b00;
      idx_q   <= '0;
      wdata_q <= 16'h0;
      err_q   <= 1'b0;
    end else if (accept) begin
      wr_q    <= wr_i;
      size_q  <= size_i;
      off_q   <= addr_i[1:0];
      idx_q   <= addr_i[ADDR_W-1:2];
      wdata_q <= wdata_i[15:0];
      err_q   <= misaligned;
    end
  end

  always_comb begin
    mergedWord = holdWord_q;
    if (size_q == 2'b00) mergedWord[{off_q, 3'b000} +: 8]     = wdata_q[7:0];
    else                 mergedWord[{off_q[1], 4'b0000} +: 16] = wdata_q;
  end

  always_comb begin
    case (size_q)
      2'b00:   loadWord = {24'h0, holdWord_q[{off_q, 3'b000} +: 8]};
      2'b01:   loadWord = {16'h0, holdWord_q[{off_q[1], 4'b0000} +: 16]};
      default: loadWord = holdWord_q;
    endcase
  end

  // Single RAM port: either the RMW merge write or the accept-edge access.
  always_comb begin
    memWe    = 1'b0;
    memIdx   = addr_i[ADDR_W-1:2];
    memWdata = wdata_i;
    if (state_q == RMW) begin
      memWe    = 1'b1;
      memIdx   = idx_q;
      memWdata = mergedWord;
    end else if (accept && !misaligned && wr_i && size_i == 2'b10) begin
      memWe = 1'b1;
    end
  end

  assign memRe = accept && !misaligned && !(wr_i && size_i == 2'b10);

  // Writes are gated by reset so that a reset during RMW leaves the word untouched.
  always_ff @(posedge clk_i) begin
    if (rstn_i && memWe) mem[memIdx] <= memWdata;
    if (memRe) holdWord_q <= mem[addr_i[ADDR_W-1:2]];
  end

endmodule
